seq_010_gen: RTL and testbench

- Serial stimulus transmitter for the "010" sequence-detector path. It drives the detector's serial X input.
- On a start command it emits a programmable number of non-overlapping "010" patterns, separated by a programmable run of idle-high '1' bits.
- It counts the patterns it has sent, so the detector's pattern counter can be checked against it.
- It sits upstream of the detector in the serial-link subsystem and in its self-check harness.

---
 rtl/seq_010_gen.sv | 129 ++++++++++++
 tb/tb_seq_010_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_010_gen.sv
// Serial "010" pattern transmitter feeding the sequence detector's X input.
// Optional abort input is enabled by defining SEQ_GEN_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start, line held at idle-high '1'
// B0    | first pattern bit '0'
// B1    | second pattern bit '1'
// B2    | third pattern bit '0', pattern counted on exit
// GAP   | idle-high '1' gap bits between patterns
// DONE  | one-cycle completion pulse
module seq_010_gen #(
    parameter int CNT_W = 10,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SEQ_GEN_ABORT_EN
    input  logic             abort,
`endif
    input  logic [CNT_W-1:0] num_pat,
    input  logic [GAP_W-1:0] gap_len,
    output logic             x_out,
    output logic             bit_valid,
    output logic             busy,
    output logic [CNT_W-1:0] pat_count,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] num_pat_q, num_pat_nx;
    logic [CNT_W-1:0] pat_count_nx;
    logic [GAP_W-1:0] gap_len_q, gap_len_nx;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
    logic             abort_req;
    logic             x_nx, bit_valid_nx, busy_nx, done_nx;

`ifdef SEQ_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        num_pat_nx   = num_pat_q;
        gap_len_nx   = gap_len_q;
        gap_cnt_nx   = gap_cnt;
        pat_count_nx = pat_count;
        case (state)
            S_IDLE: begin
                if (start) begin
                    num_pat_nx   = num_pat;
                    gap_len_nx   = gap_len;
                    pat_count_nx = '0;
                    state_nx     = (num_pat == '0) ? S_DONE : S_B0;
                end
            end
            S_B0: state_nx = S_B1;
            S_B1: state_nx = S_B2;
            S_B2: begin
                pat_count_nx = pat_count + CNT_W'(1);
                if (pat_count_nx == num_pat_q) begin
                    state_nx = S_DONE;
                end else if (gap_len_q == '0) begin
                    state_nx = S_B0;
                end else begin
                    state_nx   = S_GAP;
                    gap_cnt_nx = gap_len_q;
                end
            end
            S_GAP: begin
                // down-counter: terminal count of 1 means this is the last gap bit
                gap_cnt_nx = gap_cnt - GAP_W'(1);
                if (gap_cnt == GAP_W'(1)) begin
                    state_nx = S_B0;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort_req && (state != S_IDLE)) begin
            state_nx = S_IDLE;
        end
    end

    // outputs are decoded from the next state so they leave the flops aligned with it
    always_comb begin
        x_nx         = !((state_nx == S_B0) || (state_nx == S_B2));
        bit_valid_nx = (state_nx == S_B0) || (state_nx == S_B1) ||
                       (state_nx == S_B2) || (state_nx == S_GAP);
        busy_nx      = (state_nx != S_IDLE);
        done_nx      = (state_nx == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            num_pat_q <= '0;
            gap_len_q <= '0;
            gap_cnt   <= '0;
            pat_count <= '0;
            x_out     <= 1'b1;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            num_pat_q <= num_pat_nx;
            gap_len_q <= gap_len_nx;
            gap_cnt   <= gap_cnt_nx;
            pat_count <= pat_count_nx;
            x_out     <= x_nx;
            bit_valid <= bit_valid_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_seq_010_gen.sv
// Directed, table-driven bench for seq_010_gen.
// Abort scenarios are exercised only when SEQ_GEN_ABORT_EN is defined.
module tb_seq_010_gen;

    logic       clk_tb = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [9:0] num_pat;
    logic [3:0] gap_len;
    logic       x_out;
    logic       bit_valid;
    logic       busy;
    logic [9:0] pat_count;
    logic       done;

    int passed = 0;
    int total  = 0;

    always #5 clk_tb = ~clk_tb;

    seq_010_gen #(.CNT_W(10), .GAP_W(4)) dut (
        .clk       (clk_tb),
        .rst_n     (rst_n),
        .start     (start),
`ifdef SEQ_GEN_ABORT_EN
        .abort     (abort),
`endif
        .num_pat   (num_pat),
        .gap_len   (gap_len),
        .x_out     (x_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .pat_count (pat_count),
        .done      (done)
    );

    typedef struct {
        logic [9:0]  np;
        logic [3:0]  gp;
        int          rs;
        logic [63:0] bits;
        int          len;
        logic [9:0]  cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issues one command, optionally re-pulsing start at cycle rs, and collects the valid bits.
    task automatic run_cmd(input logic [9:0] np, input logic [3:0] gp, input int rs,
                           output logic [63:0] bits, output int len, output bit ok);
        bits = '0;
        len  = 0;
        ok   = 1'b0;
        @(negedge clk_tb);
        start   = 1'b1;
        num_pat = np;
        gap_len = gp;
        @(negedge clk_tb);
        start = 1'b0;
        for (int c = 1; c <= 200 && !ok; c++) begin
            if (bit_valid) begin
                bits = {bits[62:0], x_out};
                len++;
            end
            if (done) ok = 1'b1;
            if (c == rs) begin
                start   = 1'b1;
                num_pat = 10'd7;
                gap_len = 4'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk_tb);
        end
    endtask

    initial begin
        logic [63:0] bits;
        int          len;
        bit          ok;
        bit ex_x[5]    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bit ex_bv[5]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bit ex_done[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bit ex_busy[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        vecs[0] = '{10'd1, 4'd3,  0, 64'b010, 3, 10'd1};
        vecs[1] = '{10'd4, 4'd0,  0, 64'b010010010010, 12, 10'd4};
        vecs[2] = '{10'd0, 4'd5,  0, 64'b0, 0, 10'd0};
        vecs[3] = '{10'd2, 4'd1,  0, 64'b0101010, 7, 10'd2};
        vecs[4] = '{10'd3, 4'd2,  2, 64'b0101101011010, 13, 10'd3};
        vecs[5] = '{10'd2, 4'd15, 0, {43'b0, 3'b010, 15'h7fff, 3'b010}, 21, 10'd2};

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        num_pat = '0;
        gap_len = '0;
        @(negedge clk_tb);
        @(negedge clk_tb);
        check("rst_x_out", 64'(x_out), 64'd1);
        check("rst_bit_valid", 64'(bit_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pat_count", 64'(pat_count), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk_tb);

        // cycle-accurate timing of a single pattern with a (unused) gap of 3
        start   = 1'b1;
        num_pat = 10'd1;
        gap_len = 4'd3;
        @(negedge clk_tb);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t1_x_c%0d", k + 1), 64'(x_out), 64'(ex_x[k]));
            check($sformatf("t1_bv_c%0d", k + 1), 64'(bit_valid), 64'(ex_bv[k]));
            check($sformatf("t1_done_c%0d", k + 1), 64'(done), 64'(ex_done[k]));
            check($sformatf("t1_busy_c%0d", k + 1), 64'(busy), 64'(ex_busy[k]));
            @(negedge clk_tb);
        end
        check("t1_pat_count", 64'(pat_count), 64'd1);

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].np, vecs[i].gp, vecs[i].rs, bits, len, ok);
            check($sformatf("v%0d_done_seen", i), 64'(ok), 64'd1);
            check($sformatf("v%0d_len", i), 64'(len), 64'(vecs[i].len));
            check($sformatf("v%0d_bits", i), bits, vecs[i].bits);
            check($sformatf("v%0d_pat_count", i), 64'(pat_count), 64'(vecs[i].cnt));
            check($sformatf("v%0d_done_one_cycle", i), 64'(done), 64'd0);
            check($sformatf("v%0d_busy_low", i), 64'(busy), 64'd0);
            @(negedge clk_tb);
            check($sformatf("v%0d_pat_count_hold", i), 64'(pat_count), 64'(vecs[i].cnt));
        end

        // reset asserted during the third pattern's B1 (cycle 10 with gap 1)
        start   = 1'b1;
        num_pat = 10'd5;
        gap_len = 4'd1;
        @(negedge clk_tb);
        start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk_tb);
        check("rstmid_in_b1", 64'({bit_valid, x_out}), 64'b11);
        check("rstmid_pat_count_before", 64'(pat_count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_x_out", 64'(x_out), 64'd1);
        check("rstmid_bit_valid", 64'(bit_valid), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_pat_count", 64'(pat_count), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        @(negedge clk_tb);
        @(negedge clk_tb);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rstmid_no_done_c%0d", c), 64'({done, busy}), 64'd0);
            @(negedge clk_tb);
        end

`ifdef SEQ_GEN_ABORT_EN
        start   = 1'b1;
        num_pat = 10'd5;
        gap_len = 4'd1;
        @(negedge clk_tb);
        start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk_tb);
        abort = 1'b1;
        @(negedge clk_tb);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_bit_valid", 64'(bit_valid), 64'd0);
        check("abort_x_out", 64'(x_out), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        check("abort_pat_count", 64'(pat_count), 64'd2);
        @(negedge clk_tb);
        check("abort_pat_count_hold", 64'(pat_count), 64'd2);
        check("abort_stay_idle", 64'({busy, done}), 64'd0);

        // abort together with start in IDLE: the command is accepted
        start   = 1'b1;
        abort   = 1'b1;
        num_pat = 10'd1;
        gap_len = 4'd0;
        @(negedge clk_tb);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_wins", 64'({busy, bit_valid, x_out}), 64'b110);
        for (int c = 0; c < 5; c++) @(negedge clk_tb);
        check("abort_start_count", 64'(pat_count), 64'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
